// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_decoder_if : display bus lines plus decoded readback        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg_scan_decoder_if;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  valid;
   logic [3:0]  blank;
   logic        frame_done;
   logic        bus_err;

   modport master (
      output an, seg,
      input  digits, dp, valid, blank, frame_done, bus_err
   );

   modport slave (
      input  an, seg,
      output digits, dp, valid, blank, frame_done, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_decoder : captures stable scanned 7-seg digits back to BCD  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_scan_decoder #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 5
) (
   input  logic                clk,
   input  logic                rst,
   seg_scan_decoder_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } state_t;

   // Counter value just before the edge on which it reaches STABLE_CYCLES-1
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);

   state_t            state;
   state_t            state_nxt;
   logic [11:0]       s_cur;
   logic [11:0]       s_prv;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        cur_an;
   logic [7:0]        cur_seg;
   logic              match;
   logic              one_hot;
   logic              capture;
   logic              err_hit;
   logic [1:0]        slot;
   logic [3:0]        slot_bit;
   logic [3:0]        num;
   logic              is_num;
   logic              is_blank;
   logic [15:0]       digits_q;
   logic [3:0]        dp_q;
   logic [3:0]        valid_q;
   logic [3:0]        blank_q;
   logic [3:0]        mask;
   logic              frame_done_q;
   logic              bus_err_q;

   assign cur_an  = s_cur[11:8];
   assign cur_seg = s_cur[7:0];
   assign match   = (s_cur == s_prv);
   assign one_hot = $onehot(~cur_an);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      err_hit   = 1'b0;
      if (!match) begin
         state_nxt = one_hot ? COUNT : IDLE;
      end else begin
         case (state)
            COUNT: begin
               if (cnt == CNT_LAST) begin
                  capture   = 1'b1;
                  state_nxt = HELD;
               end
            end
            IDLE: begin
               if (cur_an != 4'hF && cnt == CNT_LAST) err_hit = 1'b1;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      slot = 2'd0;
      case (cur_an)
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: slot = 2'd0;
      endcase
      slot_bit = 4'b0001 << slot;
      num      = 4'hF;
      is_num   = 1'b1;
      case (cur_seg[6:0])
         7'h40: num = 4'd0;
         7'h79: num = 4'd1;
         7'h24: num = 4'd2;
         7'h30: num = 4'd3;
         7'h19: num = 4'd4;
         7'h12: num = 4'd5;
         7'h02: num = 4'd6;
         7'h78: num = 4'd7;
         7'h00: num = 4'd8;
         7'h10: num = 4'd9;
         default: is_num = 1'b0;
      endcase
      is_blank = (cur_seg[6:0] == 7'h7F);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_cur        <= 12'hFFF;
         s_prv        <= 12'hFFF;
         cnt          <= '0;
         digits_q     <= 16'hFFFF;
         dp_q         <= 4'h0;
         valid_q      <= 4'h0;
         blank_q      <= 4'h0;
         mask         <= 4'h0;
         frame_done_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         s_prv        <= s_cur;
         s_cur        <= {bus.an, bus.seg};
         frame_done_q <= 1'b0;
         bus_err_q    <= err_hit;
         if (!match)              cnt <= '0;
         else if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
         if (capture) begin
            digits_q[{slot, 2'b00} +: 4] <= num;
            dp_q[slot]    <= ~cur_seg[7];
            valid_q[slot] <= is_num;
            blank_q[slot] <= is_blank;
            // Completing the set of four slots closes the frame
            if ((mask | slot_bit) == 4'hF) begin
               mask         <= 4'h0;
               frame_done_q <= 1'b1;
            end else begin
               mask <= mask | slot_bit;
            end
         end
      end
   end

   assign bus.digits     = digits_q;
   assign bus.dp         = dp_q;
   assign bus.valid      = valid_q;
   assign bus.blank      = blank_q;
   assign bus.frame_done = frame_done_q;
   assign bus.bus_err    = bus_err_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_decoder : vector table, corner sequences, random + model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg_scan_decoder;
   localparam int S = 16;

   typedef struct {
      logic [3:0]  an;
      logic [7:0]  seg;
      logic [15:0] digits;
      logic [3:0]  valid;
      logic [3:0]  blank;
      logic [3:0]  dp;
      int          fd;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_decoder_if bus();

   seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int fd_cnt  = 0;
   int err_cnt = 0;

   // Reference: a pattern is acted on at the edge after it has been sampled S times in a row
   logic [3:0]  m_dig [4];
   logic [3:0]  m_dp, m_val, m_blk, m_mask;
   logic        m_fd, m_err;
   logic [11:0] hist [$];
   logic [6:0]  codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
      m_dp = 0; m_val = 0; m_blk = 0; m_mask = 0; m_fd = 0; m_err = 0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(12'hFFF);
   endtask

   task automatic model_edge(input logic r, input logic [11:0] smp);
      logic [11:0] p;
      logic        run_ok;
      int          zeros, sl, n;
      m_fd = 0; m_err = 0;
      if (r) begin
         model_reset();
         return;
      end
      p = hist[0];
      run_ok = 1'b1;
      for (int i = 0; i < S; i++) if (hist[i] != p) run_ok = 1'b0;
      if (hist[S] == p) run_ok = 1'b0;
      if (run_ok) begin
         zeros = 0; sl = 0;
         for (int i = 0; i < 4; i++) if (!p[8+i]) begin zeros++; sl = i; end
         if (zeros == 1) begin
            n = 15;
            for (int j = 0; j < 10; j++) if (codes[j] == p[6:0]) n = j;
            m_dig[sl] = 4'(n);
            m_val[sl] = (n < 10);
            m_blk[sl] = (p[6:0] == 7'h7F);
            m_dp[sl]  = !p[7];
            m_mask[sl] = 1'b1;
            if (m_mask == 4'hF) begin m_fd = 1; m_mask = 0; end
         end else if (p[11:8] != 4'hF) begin
            m_err = 1;
         end
      end
      hist.push_front(smp);
      void'(hist.pop_back());
   endtask

   task automatic check_all();
      logic [33:0] got, exp;
      got = {bus.digits, bus.dp, bus.valid, bus.blank, bus.frame_done, bus.bus_err};
      exp = {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp, m_val, m_blk, m_fd, m_err};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL cycle_model t=%0t: got=%h exp=%h", $time, got, exp);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(rst, {bus.an, bus.seg});
      #1;
      fd_cnt  += int'(bus.frame_done);
      err_cnt += int'(bus.bus_err);
      check_all();
   endtask

   task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
      bus.an = a; bus.seg = s;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   vec_t tbl [8];

   initial begin
      tbl[0] = '{4'b1110, 8'hC0, 16'hFFF0, 4'b0001, 4'b0000, 4'b0000, 0};
      tbl[1] = '{4'b1110, 8'hF9, 16'hFFF1, 4'b0001, 4'b0000, 4'b0000, 0};
      tbl[2] = '{4'b1101, 8'hA4, 16'hFF21, 4'b0011, 4'b0000, 4'b0000, 0};
      tbl[3] = '{4'b1011, 8'h30, 16'hF321, 4'b0111, 4'b0000, 4'b0100, 0};
      tbl[4] = '{4'b0111, 8'h99, 16'h4321, 4'b1111, 4'b0000, 4'b0100, 1};
      tbl[5] = '{4'b0111, 8'hFF, 16'hF321, 4'b0111, 4'b1000, 4'b0100, 0};
      tbl[6] = '{4'b0111, 8'h8C, 16'hF321, 4'b0111, 4'b0000, 4'b0100, 0};
      tbl[7] = '{4'b1110, 8'h40, 16'hF320, 4'b0111, 4'b0000, 4'b0101, 0};

      bus.an = 4'hF; bus.seg = 8'hFF;
      do_reset();
      chk("reset_digits", 32'(bus.digits), 32'hFFFF);
      chk("reset_flags", 32'({bus.dp, bus.valid, bus.blank, bus.frame_done, bus.bus_err}), 32'h0);

      // Table: each entry held long enough for one capture
      for (int v = 0; v < 8; v++) begin
         fd_cnt = 0;
         drive(tbl[v].an, tbl[v].seg, 20);
         chk($sformatf("tbl%0d_digits", v), 32'(bus.digits), 32'(tbl[v].digits));
         chk($sformatf("tbl%0d_valid", v),  32'(bus.valid),  32'(tbl[v].valid));
         chk($sformatf("tbl%0d_blank", v),  32'(bus.blank),  32'(tbl[v].blank));
         chk($sformatf("tbl%0d_dp", v),     32'(bus.dp),     32'(tbl[v].dp));
         chk($sformatf("tbl%0d_frame", v),  32'(fd_cnt),     32'(tbl[v].fd));
      end

      // Exact capture latency
      do_reset();
      drive(4'b1110, 8'hC0, S);
      chk("lat_before", 32'(bus.digits), 32'hFFFF);
      drive(4'b1110, 8'hC0, 1);
      chk("lat_at", 32'(bus.digits), 32'hFFF0);
      chk("lat_valid", 32'(bus.valid), 32'h1);
      drive(4'b1110, 8'hC0, 10);

      // Short glitch ignored
      do_reset();
      drive(4'b1011, 8'hC0, 10);
      drive(4'b1011, 8'hF9, 20);
      chk("glitch_digits", 32'(bus.digits), 32'hF1FF);
      chk("glitch_valid", 32'(bus.valid), 32'h4);

      // Two anodes low then all off
      err_cnt = 0;
      drive(4'b1100, 8'hC0, 20);
      chk("buserr_count", 32'(err_cnt), 32'd1);
      chk("buserr_digits", 32'(bus.digits), 32'hF1FF);
      err_cnt = 0;
      drive(4'b1111, 8'hC0, 20);
      chk("alloff_silent", 32'(err_cnt), 32'd0);

      // Reset mid-window discards the partial count
      do_reset();
      drive(4'b1110, 8'hC0, 11);
      do_reset();
      drive(4'b1110, 8'hC0, S);
      chk("rstwin_before", 32'(bus.digits), 32'hFFFF);
      drive(4'b1110, 8'hC0, 1);
      chk("rstwin_after", 32'(bus.digits), 32'hFFF0);

      // Randomized patterns against the reference model
      for (int n = 0; n < 220; n++) begin
         logic [3:0] a;
         logic [7:0] s;
         int k;
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2, 3, 4, 5: a = ~(4'b0001 << $urandom_range(0, 3));
            6:                a = 4'hF;
            7:                a = 4'($urandom_range(0, 15));
            default:          a = ~((4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3)));
         endcase
         k = $urandom_range(0, 11);
         if (k < 10)       s = {1'($urandom_range(0, 1)), codes[k]};
         else if (k == 10) s = {1'($urandom_range(0, 1)), 7'h7F};
         else              s = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 24) == 0) do_reset();
         drive(a, s, $urandom_range(1, 24));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
